xyz_to_cct_estimator: RTL and testbench
=======================================

Name: xyz_to_cct_estimator

Overview:
- Inverse of the CCT-to-XYZ path. Takes a packed tristimulus XYZ (Q16.16 unsigned) and estimates correlated colour temperature in Kelvin using McCamy's formula.
- Sits after the XYZ measurement/adaptation stage. Its output feeds CCT-domain logic (white-point tracking, ALS cross-check).
- Sequential: one shared restoring divider plus a 3-step Horner polynomial. One conversion in flight at a time.

Parameters:
- CCT_MIN, 16'd3000, lower output clamp in Kelvin.
- CCT_MAX, 16'd8000, upper output clamp in Kelvin.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- xyz_in  in  96  packed Q16.16 unsigned: X=[31:0], Y=[63:32], Z=[95:64].
- xyz_valid  in  1  input sample valid. Accepted only when in_ready=1.
- in_ready  out  1  high in IDLE. Equals (state==IDLE).
- cct_out  out  16  estimated CCT in Kelvin, clamped to [CCT_MIN, CCT_MAX].
- cct_valid  out  1  one-cycle pulse when cct_out updates.
- cct_err  out  1  qualified by cct_valid. 1 = degenerate input (X+Y+Z==0).

Behaviour:
- Reset state: IDLE. Outputs at reset: in_ready=1, cct_out=CCT_MIN, cct_valid=0, cct_err=0. All datapath registers cleared.
- Reset mid-operation aborts the conversion immediately: no cct_valid, back to IDLE.
- Accept: on the edge where xyz_valid & in_ready, latch X, Y, Z and go to PREP.
- xyz_valid while busy is ignored. There is no queue and no error.
- PREP (1 cycle): compute S = X+Y+Z (34-bit unsigned), then:
  - N = X - ((S*21758)>>16)
  - D = ((S*12177)>>16) - Y
  - 21758 = 0.3320 and 12177 = 0.1858 in Q16.16.
  - N and D are signed, at least 36 bits.
  - If S==0, skip to the output step with cct_out=CCT_MIN and cct_err=1 (latency is unchanged, see below).
- DIV (32 cycles):
  - Unsigned restoring divide (|N|<<16)/|D|, one quotient bit per cycle.
  - Sign = sign(N) xor sign(D).
  - Result n is Q16.16 signed.
- Saturate n to [-32768, +32768] (±0.5) after the divide.
- D==0: n = +0.5 if N>=0, else -0.5. The divider still runs its 32 cycles.
- POLY1..POLY3 (1 cycle each), Horner evaluation with signed 64-bit products, arithmetic shift >>>16, truncate to 32 bits:
  - POLY1: a = 449*n + (3525<<16)
  - POLY2: b = a*n + 447171789 (6823.3 in Q16.16)
  - POLY3: p = b*n + 361780347 (5520.33 in Q16.16)
  - k = (p + 32768) >>> 16 (round half up).
  - Clamp k to [CCT_MIN, CCT_MAX]. Negative k clamps to CCT_MIN.
- Output step: on the edge leaving POLY3, register cct_out and cct_err, pulse cct_valid for exactly one cycle, return to IDLE.
  - in_ready is already 1 in the cycle where cct_valid is 1.
  - A new xyz_valid in that cycle is accepted.
- Latency: cct_valid is high in the cycle following the 36th rising edge after the accepting edge. This holds for every input, including S==0 and D==0.
- Throughput: one result per 37 cycles maximum.
- cct_out holds its last value between results.
- Truncation/rounding error vs. the double-precision McCamy result: ≤ ±2 K over [CCT_MIN, CCT_MAX].
- States: IDLE, PREP, DIV, POLY1, POLY2, POLY3. An illegal encoding returns to IDLE.

Test Plan:
- D65 (X=62293, Y=65536, Z=71368), single pulse -> cct_valid exactly 36 cycles after acceptance, cct_out = 6504 ±2, cct_err=0, in_ready low throughout the conversion.
- D50 (63190, 65536, 54074) -> cct_out = 5001 ±2. Immediately re-pulse in the cct_valid cycle with D65 -> second input accepted, result 6504 ±2 after 36 more cycles.
- Illuminant A (71991, 65536, 23317) -> n saturates to -0.5, polynomial ≈ 2933, cct_out = 3000 (CCT_MIN). Bluish (62000, 70000, 140000) -> cct_out = 8000 (CCT_MAX).
- XYZ all zero -> cct_valid after 36 cycles, cct_out = 3000, cct_err = 1. Next valid D65 input -> cct_err = 0.
- Pulse xyz_valid at cycles 5, 20 and 30 during a conversion -> all ignored, exactly one cct_valid, result matches the first input.
- Assert rst_n low during DIV (cycle 15) -> outputs return to reset values asynchronously, no cct_valid. After release, the next input converts normally.

Source files
------------

// File: rtl/xyz_to_cct_estimator.sv
// xyz_to_cct_estimator: estimates correlated colour temperature (Kelvin) from a
// Q16.16 XYZ tristimulus sample using McCamy's cubic. One conversion in flight;
// a shared restoring divider forms n = (x - 0.3320) / (0.1858 - y), then a
// three-step Horner evaluation produces the clamped CCT.
module xyz_to_cct_estimator #(
   parameter logic [15:0] CCT_MIN = 16'd3000,
   parameter logic [15:0] CCT_MAX = 16'd8000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [95:0] xyz_in,
   input  logic        xyz_valid,
   output logic        in_ready,
   output logic [15:0] cct_out,
   output logic        cct_valid,
   output logic        cct_err
);

   localparam int unsigned SW = 34;   // X+Y+Z
   localparam int unsigned MW = 50;   // S times a Q0.16 chromaticity constant
   localparam int unsigned NW = 36;   // signed numerator / denominator
   localparam int unsigned RW = 37;   // divider partial remainder
   localparam int unsigned QW = 32;   // quotient bits, one per DIV cycle
   localparam int unsigned CW = 5;    // DIV cycle counter
   localparam int unsigned PW = 64;   // Horner product width

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PREP  = 3'd1;
   localparam logic [2:0] ST_DIV   = 3'd2;
   localparam logic [2:0] ST_POLY1 = 3'd3;
   localparam logic [2:0] ST_POLY2 = 3'd4;
   localparam logic [2:0] ST_POLY3 = 3'd5;

   localparam logic [CW-1:0] DIV_LAST = CW'(31);
   localparam logic [15:0]   C_XE     = 16'd21758;     // 0.3320
   localparam logic [15:0]   C_YE     = 16'd12177;     // 0.1858
   localparam logic [15:0]   N_SAT    = 16'd32768;     // |n| limit of 0.5
   localparam logic signed [PW-1:0] C_CUBE = 64'sd29425664;   // 449 in Q16.16
   localparam logic signed [31:0]   C_SQR  = 32'sd231014400;  // 3525 in Q16.16
   localparam logic signed [31:0]   C_LIN  = 32'sd447171789;  // 6823.3 in Q16.16
   localparam logic signed [31:0]   C_OFS  = 32'sd361780347;  // 5520.33 in Q16.16
   localparam logic signed [31:0]   HALF   = 32'sd32768;
   localparam logic signed [31:0]   K_MIN  = $signed({16'b0, CCT_MIN});
   localparam logic signed [31:0]   K_MAX  = $signed({16'b0, CCT_MAX});

   logic [2:0]        state_q, state_d;
   logic              valid_d, ready_d;

   logic [31:0]       x_q, y_q, z_q;
   logic [NW-1:0]     mag_d_q;
   logic              neg_q, err_q, ovf_q;
   logic [RW-1:0]     rem_q;
   logic [QW-1:0]     dvd_q, quo_q;
   logic [CW-1:0]     cnt_q;
   logic signed [31:0] n_q, acc_q;

   logic [SW-1:0]     s_c;
   logic [MW-1:0]     sx_c, sy_c;
   logic [NW-1:0]     n_raw_c, d_raw_c, mag_n_c, mag_d_c;
   logic [RW-1:0]     r_sh_c, r_sub_c;
   logic              r_ge_c;
   logic [15:0]       m_c;
   logic signed [31:0] n_sat_c;
   logic signed [PW-1:0] mul_a_c, mul_b_c, prod_c;
   logic signed [31:0] add_c, poly_c, k_c;
   logic [15:0]       cct_c;

   // Chromaticity numerator/denominator and their magnitudes for the divider
   always_comb begin
      s_c     = SW'(x_q) + SW'(y_q) + SW'(z_q);
      sx_c    = MW'(s_c) * MW'(C_XE);
      sy_c    = MW'(s_c) * MW'(C_YE);
      n_raw_c = NW'(x_q) - NW'(sx_c >> 16);
      d_raw_c = NW'(sy_c >> 16) - NW'(y_q);
      mag_n_c = n_raw_c[NW-1] ? (~n_raw_c + NW'(1)) : n_raw_c;
      mag_d_c = d_raw_c[NW-1] ? (~d_raw_c + NW'(1)) : d_raw_c;
   end

   // One restoring-divide step: shift in the next dividend bit, trial subtract
   always_comb begin
      r_sh_c  = RW'({rem_q, dvd_q[QW-1]});
      r_ge_c  = (r_sh_c >= {1'b0, mag_d_q});
      r_sub_c = r_sh_c - {1'b0, mag_d_q};
   end

   // Signed, saturated n; a zero denominator always lands in the overflow case
   always_comb begin
      m_c     = (ovf_q || (quo_q > QW'(N_SAT))) ? N_SAT : quo_q[15:0];
      n_sat_c = neg_q ? (32'sd0 - $signed({16'b0, m_c})) : $signed({16'b0, m_c});
   end

   // Shared Horner multiply-add; POLY1 uses the cubic coefficient as multiplicand
   always_comb begin
      mul_a_c = acc_q;
      mul_b_c = n_q;
      add_c   = C_LIN;
      case (state_q)
         ST_POLY1: begin
            mul_a_c = C_CUBE;
            mul_b_c = n_sat_c;
            add_c   = C_SQR;
         end
         ST_POLY3: add_c = C_OFS;
         default:  ;
      endcase
      prod_c = mul_a_c * mul_b_c;
      poly_c = 32'(prod_c >>> 16) + add_c;
      k_c    = (poly_c + HALF) >>> 16;
      if (k_c < K_MIN)      cct_c = CCT_MIN;
      else if (k_c > K_MAX) cct_c = CCT_MAX;
      else                  cct_c = k_c[15:0];
   end

   // Next-state and next-output decode
   always_comb begin
      state_d = state_q;
      valid_d = 1'b0;
      case (state_q)
         ST_IDLE:  if (xyz_valid) state_d = ST_PREP;
         ST_PREP:  state_d = ST_DIV;
         ST_DIV:   if (cnt_q == DIV_LAST) state_d = ST_POLY1;
         ST_POLY1: state_d = ST_POLY2;
         ST_POLY2: state_d = ST_POLY3;
         ST_POLY3: begin
            state_d = ST_IDLE;
            valid_d = 1'b1;
         end
         default:  state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   // State register and handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         in_ready  <= 1'b1;
         cct_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_ready  <= ready_d;
         cct_valid <= valid_d;
      end
   end

   // Datapath: latch, prepare divide, iterate, evaluate polynomial, publish
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         mag_d_q <= '0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         rem_q   <= '0;
         dvd_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         n_q     <= '0;
         acc_q   <= '0;
         cct_out <= CCT_MIN;
         cct_err <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (xyz_valid) begin
                  x_q <= xyz_in[31:0];
                  y_q <= xyz_in[63:32];
                  z_q <= xyz_in[95:64];
               end
            end
            ST_PREP: begin
               err_q   <= (s_c == '0);
               neg_q   <= n_raw_c[NW-1] ^ d_raw_c[NW-1];
               mag_d_q <= mag_d_c;
               // Quotient would need more than 32 bits: n saturates regardless
               ovf_q   <= (RW'(mag_n_c[NW-1:16]) >= RW'(mag_d_c));
               rem_q   <= RW'(mag_n_c[NW-1:16]);
               dvd_q   <= {mag_n_c[15:0], 16'b0};
               quo_q   <= '0;
               cnt_q   <= '0;
            end
            ST_DIV: begin
               rem_q <= r_ge_c ? r_sub_c : r_sh_c;
               quo_q <= {quo_q[QW-2:0], r_ge_c};
               dvd_q <= {dvd_q[QW-2:0], 1'b0};
               cnt_q <= cnt_q + CW'(1);
            end
            ST_POLY1: begin
               n_q   <= n_sat_c;
               acc_q <= poly_c;
            end
            ST_POLY2: acc_q <= poly_c;
            ST_POLY3: begin
               cct_out <= err_q ? CCT_MIN : cct_c;
               cct_err <= err_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_xyz_to_cct_estimator.sv
// Scoreboard bench for xyz_to_cct_estimator: expected results come from an
// integer McCamy model built on plain division, pushed when a sample is driven
// and compared (value, error flag, latency) when cct_valid arrives.
module tb_xyz_to_cct_estimator;

   localparam int LAT = 36;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [95:0] xyz_in = '0;
   logic        xyz_valid = 1'b0;
   logic        in_ready;
   logic [15:0] cct_out;
   logic        cct_valid;
   logic        cct_err;

   xyz_to_cct_estimator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .xyz_in    (xyz_in),
      .xyz_valid (xyz_valid),
      .in_ready  (in_ready),
      .cct_out   (cct_out),
      .cct_valid (cct_valid),
      .cct_err   (cct_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          acc;
      int          due;
      logic [15:0] cct;
      logic        err;
      int          ref_k;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: McCamy in Q16.16 integer arithmetic with a direct divide
   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] z,
                                 output logic [15:0] k, output logic e);
      longint s, n, d, an, ad, q, m, nn, a, b, p, kk;
      s  = longint'(x) + longint'(y) + longint'(z);
      n  = longint'(x) - ((s * 21758) >>> 16);
      d  = ((s * 12177) >>> 16) - longint'(y);
      an = (n < 0) ? -n : n;
      ad = (d < 0) ? -d : d;
      if (ad == 0) m = 32768;
      else begin
         q = (an <<< 16) / ad;
         m = (q > 32768) ? 32768 : q;
      end
      nn = ((n < 0) != (d < 0)) ? -m : m;
      a  = 449 * nn + 231014400;
      b  = ((a * nn) >>> 16) + 447171789;
      p  = ((b * nn) >>> 16) + 361780347;
      kk = (p + 32768) >>> 16;
      e  = (s == 0);
      if (e || kk < 3000) k = 16'd3000;
      else if (kk > 8000) k = 16'd8000;
      else                k = 16'(kk);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one sample in a cycle where in_ready is known high
   task automatic drive(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z, input int ref_k);
      exp_t        e;
      logic [15:0] k;
      logic        er;
      model(x, y, z, k, er);
      e.acc   = cyc + 1;
      e.due   = cyc + 1 + LAT;
      e.cct   = k;
      e.err   = er;
      e.ref_k = ref_k;
      sb.push_back(e);
      xyz_in    = {z, y, x};
      xyz_valid = 1'b1;
      tick();
      xyz_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) chk("ready_timeout", 0, 1);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!cct_valid && n < 100) begin
         tick();
         n++;
      end
      if (!cct_valid) chk("valid_timeout", 0, 1);
   endtask

   task automatic send(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] z, input int ref_k);
      wait_ready();
      drive(x, y, z, ref_k);
   endtask

   // Output monitor: in_ready shape, result, error flag, latency, tolerance
   exp_t m_e;
   logic m_busy;
   int   m_dk;
   always @(posedge clk) begin
      #2;
      if (rst_n) begin
         m_busy = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].due);
         chk("in_ready", in_ready, !m_busy);
         if (cct_valid) begin
            if (sb.size() == 0) chk("spurious_valid", 1, 0);
            else begin
               m_e = sb.pop_front();
               chk("latency", cyc, m_e.due);
               chk("cct_out", cct_out, m_e.cct);
               chk("cct_err", cct_err, m_e.err);
               if (m_e.ref_k >= 0) begin
                  m_dk = int'(cct_out) - m_e.ref_k;
                  if (m_dk < 0) m_dk = -m_dk;
                  chk("cct_vs_mccamy_within_2k", (m_dk <= 2), 1);
               end
            end
         end else if (sb.size() > 0 && cyc >= sb[0].due) begin
            chk("missing_valid", 0, 1);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      int n;
      repeat (3) tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_cct_out", cct_out, 3000);
      chk("rst_cct_valid", cct_valid, 0);
      chk("rst_cct_err", cct_err, 0);
      rst_n = 1'b1;
      tick();

      // D65, then D50 with D65 re-issued in the D50 result cycle
      send(32'd62293, 32'd65536, 32'd71368, 6504);
      send(32'd63190, 32'd65536, 32'd54074, 5001);
      wait_valid();
      drive(32'd62293, 32'd65536, 32'd71368, 6504);

      // Clamp extremes: illuminant A low, bluish high
      send(32'd71991, 32'd65536, 32'd23317, -1);
      send(32'd62000, 32'd70000, 32'd140000, -1);

      // Degenerate all-zero input, then a normal one clears the error
      send(32'd0, 32'd0, 32'd0, -1);
      send(32'd62293, 32'd65536, 32'd71368, 6504);

      // Pulses while busy must be dropped
      send(32'd63190, 32'd65536, 32'd54074, 5001);
      for (int i = 1; i <= 34; i++) begin
         if (i == 5 || i == 20 || i == 30) begin
            xyz_in    = {32'd140000, 32'd70000, 32'd62000};
            xyz_valid = 1'b1;
         end else xyz_valid = 1'b0;
         tick();
      end
      xyz_valid = 1'b0;
      wait_ready();
      tick();

      // Asynchronous reset in the middle of the divide
      send(32'd62293, 32'd65536, 32'd71368, 6504);
      repeat (15) tick();
      #3;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("async_rst_in_ready", in_ready, 1);
      chk("async_rst_cct_out", cct_out, 3000);
      chk("async_rst_cct_valid", cct_valid, 0);
      chk("async_rst_cct_err", cct_err, 0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (40) tick();
      send(32'd62293, 32'd65536, 32'd71368, 6504);

      // A few random samples against the model
      for (int i = 0; i < 6; i++)
         send($urandom_range(250000, 0), $urandom_range(250000, 0),
              $urandom_range(250000, 0), -1);

      n = 0;
      while (sb.size() > 0 && n < 200) begin
         tick();
         n++;
      end
      if (sb.size() > 0) chk("drain_timeout", 0, 1);
      repeat (5) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
